// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares a single-port tri-state RAM between the fetch (I) and
//            load/store (D) ports, with bus turnaround on direction change.
// Options  : RAM_ARB_PERF_EN adds the saturating wait_cnt output.
// Revision : 1.0
// ============================================================================
module ram_arbiter #(
    parameter int DW = 32,
    parameter int AW = 16
`ifdef RAM_ARB_PERF_EN
    ,
    parameter int PERF_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    inout  wire  [DW-1:0]     ram_data,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_rdEn,
    output logic              ram_wrEn,
`ifdef RAM_ARB_PERF_EN
    output logic [PERF_W-1:0] wait_cnt,
`endif
    output logic              busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_rd   = 2'd1;
    localparam logic [1:0] c_wr   = 2'd2;
    localparam logic [1:0] c_turn = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_rden_q, ram_rden_d;
    logic          ram_wren_q, ram_wren_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;       // 1 = D port owns the access
    logic          pend_q, pend_d;         // winner parked during TURN (1 = D)
    logic          last_dir_q, last_dir_d; // 1 = last access was a write
    logic          i_gnt_q, i_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          i_rvalid_q, i_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic w_cand_i, w_cand_d, w_go, w_win_d, w_win_we;

    // The port granted in the ending cycle is masked so a held request is never issued twice.
    assign w_cand_d = d_req & ~d_gnt_q;
    assign w_cand_i = i_req & ~i_gnt_q;
    assign w_go     = (state_q == c_turn) ? 1'b1 : (w_cand_d | w_cand_i);
    assign w_win_d  = (state_q == c_turn) ? pend_q : w_cand_d;
    assign w_win_we = w_win_d & d_we;

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        ram_rden_d = 1'b0;
        ram_wren_d = 1'b0;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        pend_d     = pend_q;
        last_dir_d = last_dir_q;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (state_q == c_rd) begin
            if (owner_q) begin
                d_rdata_d  = ram_data;
                d_rvalid_d = 1'b1;
            end else begin
                i_rdata_d  = ram_data;
                i_rvalid_d = 1'b1;
            end
        end

        if (!w_go) begin
            state_d = c_idle;
        end else if (state_q != c_turn && w_win_we != last_dir_q) begin
            state_d = c_turn;
            pend_d  = w_win_d;
        end else begin
            state_d    = w_win_we ? c_wr : c_rd;
            ram_addr_d = w_win_d ? d_addr : i_addr;
            ram_rden_d = ~w_win_we;
            ram_wren_d = w_win_we;
            wdata_d    = w_win_we ? d_wdata : wdata_q;
            owner_d    = w_win_d;
            last_dir_d = w_win_we;
            i_gnt_d    = ~w_win_d;
            d_gnt_d    = w_win_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_idle;
            ram_addr_q <= '0;
            ram_rden_q <= 1'b0;
            ram_wren_q <= 1'b0;
            wdata_q    <= '0;
            owner_q    <= 1'b0;
            pend_q     <= 1'b0;
            last_dir_q <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_rden_q <= ram_rden_d;
            ram_wren_q <= ram_wren_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            pend_q     <= pend_d;
            last_dir_q <= last_dir_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign ram_data = ram_wren_q ? wdata_q : {DW{1'bz}};
    assign ram_addr = ram_addr_q;
    assign ram_rdEn = ram_rden_q;
    assign ram_wrEn = ram_wren_q;
    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != c_idle);

`ifdef RAM_ARB_PERF_EN
    logic [PERF_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [PERF_W:0]   w_wait_sum;
    logic [1:0]        w_wait_inc;

    // Each waiting port adds one per cycle; the sum saturates at all-ones.
    always_comb begin
        w_wait_inc = {1'b0, i_req & ~i_gnt_q} + {1'b0, d_req & ~d_gnt_q};
        w_wait_sum = {1'b0, wait_cnt_q} + {{(PERF_W-1){1'b0}}, w_wait_inc};
        wait_cnt_d = w_wait_sum[PERF_W] ? {PERF_W{1'b1}} : w_wait_sum[PERF_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed table-driven bench for ram_arbiter with a small RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] i_rdata, d_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_rdEn, ram_wrEn, busy;
    wire  [DW-1:0] ram_data;
`ifdef RAM_ARB_PERF_EN
    logic [15:0]   wait_cnt;
`endif

    logic [DW-1:0] mem [16];
    int n_checks = 0;
    int n_err    = 0;

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_rdEn(ram_rdEn), .ram_wrEn(ram_wrEn),
`ifdef RAM_ARB_PERF_EN
        .wait_cnt(wait_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: drives the bus while read-enabled, stores on write-enable
    assign ram_data = ram_rdEn ? mem[ram_addr] : 8'hzz;
    always @(posedge clk) if (ram_wrEn) mem[ram_addr] <= ram_data;

    typedef struct {
        logic        ireq;
        logic [3:0]  iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  daddr;
        logic [7:0]  dwd;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs [19];

    // flags = {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_rdEn, ram_wrEn, busy}
    function automatic logic [26:0] E(input logic [6:0] flags, input logic [3:0] a,
                                      input logic [7:0] ir, input logic [7:0] dr);
        return {flags, a, ir, dr};
    endfunction

    function automatic vec_t mk(input logic ireq, input logic [3:0] ia, input logic dreq,
                                input logic dwe, input logic [3:0] da, input logic [7:0] wd,
                                input logic [26:0] e);
        vec_t v;
        v.ireq = ireq; v.iaddr = ia; v.dreq = dreq; v.dwe = dwe;
        v.daddr = da; v.dwd = wd; v.exp = e;
        return v;
    endfunction

    function automatic logic [26:0] obs();
        return {i_gnt, d_gnt, i_rvalid, d_rvalid, ram_rdEn, ram_wrEn, busy,
                ram_addr, i_rdata, d_rdata};
    endfunction

    task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwd;
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);

        // Each row: outputs expected in this cycle, inputs driven for this cycle
        vecs[0]  = mk(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b0000000, 4'd0, 8'h00, 8'h00));
        vecs[1]  = mk(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b1000101, 4'd1, 8'h00, 8'h00));
        vecs[2]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b0010000, 4'd1, 8'h31, 8'h00));
        vecs[3]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 8'hA5, E(7'b0000000, 4'd1, 8'h31, 8'h00));
        vecs[4]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 8'hA5, E(7'b0000001, 4'd1, 8'h31, 8'h00));
        vecs[5]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 8'hA5, E(7'b0100011, 4'd2, 8'h31, 8'h00));
        vecs[6]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 8'h00, E(7'b0000000, 4'd2, 8'h31, 8'h00));
        vecs[7]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 8'h00, E(7'b0000001, 4'd2, 8'h31, 8'h00));
        vecs[8]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 8'h00, E(7'b0100101, 4'd2, 8'h31, 8'h00));
        vecs[9]  = mk(1'b1, 4'd3, 1'b1, 1'b0, 4'd4, 8'h00, E(7'b0001000, 4'd2, 8'h31, 8'hA5));
        vecs[10] = mk(1'b1, 4'd3, 1'b1, 1'b0, 4'd4, 8'h00, E(7'b0100101, 4'd4, 8'h31, 8'hA5));
        vecs[11] = mk(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b1001101, 4'd3, 8'h31, 8'h34));
        vecs[12] = mk(1'b1, 4'd5, 1'b1, 1'b0, 4'd6, 8'h00, E(7'b0010000, 4'd3, 8'h33, 8'h34));
        vecs[13] = mk(1'b1, 4'd5, 1'b1, 1'b0, 4'd6, 8'h00, E(7'b0100101, 4'd6, 8'h33, 8'h34));
        vecs[14] = mk(1'b1, 4'd5, 1'b1, 1'b0, 4'd7, 8'h00, E(7'b1001101, 4'd5, 8'h33, 8'h36));
        vecs[15] = mk(1'b1, 4'd8, 1'b1, 1'b0, 4'd7, 8'h00, E(7'b0110101, 4'd7, 8'h35, 8'h36));
        vecs[16] = mk(1'b1, 4'd8, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b1001101, 4'd8, 8'h35, 8'h37));
        vecs[17] = mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b0010000, 4'd8, 8'h38, 8'h37));
        vecs[18] = mk(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, E(7'b0000000, 4'd8, 8'h38, 8'h37));

        @(negedge clk);
        chk("reset_state", obs(), 27'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            chk($sformatf("row%0d", k), obs(), vecs[k].exp);
            if (vecs[k].exp[21])
                chk($sformatf("row%0d_bus", k), {19'd0, ram_data}, {19'd0, vecs[k].dwd});
            apply(vecs[k]);
        end

        // Reset asserted in the middle of a read access
        @(negedge clk);
        i_req = 1'b1; i_addr = 4'd9;
        @(negedge clk);
        chk("rst_rd", obs(), E(7'b1000101, 4'd9, 8'h38, 8'h37));
        reset = 1'b1;
        i_req = 1'b0;
        #1;
        chk("rst_async", obs(), 27'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", k), obs(), 27'd0);
        end

        // First write after reset needs a turnaround because last_dir resets to read
        d_req = 1'b1; d_we = 1'b1; d_addr = 4'd10; d_wdata = 8'h5A;
        @(negedge clk);
        chk("wr_turn", obs(), E(7'b0000001, 4'd0, 8'h00, 8'h00));
        @(negedge clk);
        chk("wr_acc", obs(), E(7'b0100011, 4'd10, 8'h00, 8'h00));
        chk("wr_bus", {19'd0, ram_data}, {19'd0, 8'h5A});
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        chk("wr_done", obs(), E(7'b0000000, 4'd10, 8'h00, 8'h00));
        chk("wr_mem", {19'd0, mem[10]}, {19'd0, 8'h5A});

`ifdef RAM_ARB_PERF_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("perf_reset", {11'd0, wait_cnt}, 27'd0);
        i_req = 1'b1; i_addr = 4'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 4'd4;
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        chk("perf_wait", {11'd0, wait_cnt}, 27'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
